// File: rtl/ingress_writer.sv
// Four independent ports route packets into per-destination input-RAM queues. Writes land one cycle after accept.
// in_ready drops only on a full queue in mid-packet or while reset_rams is set. Define INGRESS_PKT_COUNT_EN for counters.
module ingress_writer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        reset_rams,
  input  logic [DATA_W-1:0] in_data          [4],
  input  logic              in_valid         [4],
  output logic              in_ready         [4],
  output logic [DATA_W-1:0] ram_wr_data      [4],
  output logic [ADDR_W-1:0] ram_wr_addr      [4],
  output logic              ram_wren         [4][4],
  output logic [ADDR_W-1:0] input_ram_wr_add [4][4],
  output logic [15:0]       pkt_count        [4],
  output logic [15:0]       drop_count       [4]
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;
  localparam logic [ADDR_W-1:0] FULL_CNT = '1;

  state_t            state     [4];
  logic [1:0]        dst       [4];
  logic [ADDR_W-1:0] next_addr [4][4];
  logic              full      [4][4];
  logic              accept    [4];
  logic              nonzero   [4];
  logic [1:0]        hdr_dst   [4];
  logic              clr;

  assign clr = |reset_rams;

  // Occupancy counts the write still in flight, so back-to-back words get consecutive addresses.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 4; d++) begin
        next_addr[i][d] = input_ram_wr_add[i][d] + {{(ADDR_W-1){1'b0}}, ram_wren[i][d]};
        full[i][d]      = (next_addr[i][d] == FULL_CNT);
      end
      nonzero[i]  = |in_data[i];
      hdr_dst[i]  = in_data[i][1:0];
      in_ready[i] = !clr && !(state[i] == PAYLOAD && full[i][dst[i]]);
      accept[i]   = in_valid[i] && in_ready[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state[i]       <= IDLE;
        dst[i]         <= '0;
        ram_wr_data[i] <= '0;
        ram_wr_addr[i] <= '0;
        for (int d = 0; d < 4; d++) begin
          ram_wren[i][d]         <= 1'b0;
          input_ram_wr_add[i][d] <= '0;
        end
      end
    end else if (clr) begin
      for (int i = 0; i < 4; i++) begin
        state[i]       <= IDLE;
        dst[i]         <= '0;
        ram_wr_data[i] <= '0;
        ram_wr_addr[i] <= '0;
        for (int d = 0; d < 4; d++) begin
          ram_wren[i][d]         <= 1'b0;
          input_ram_wr_add[i][d] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int d = 0; d < 4; d++) begin
          ram_wren[i][d] <= 1'b0;
          if (ram_wren[i][d])
            input_ram_wr_add[i][d] <= input_ram_wr_add[i][d] + ADDR_W'(1);
        end
        if (accept[i]) begin
          case (state[i])
            IDLE: begin
              if (nonzero[i]) begin
                if (full[i][hdr_dst[i]]) begin
                  state[i] <= DROP;
                end else begin
                  state[i]                   <= PAYLOAD;
                  dst[i]                     <= hdr_dst[i];
                  ram_wren[i][hdr_dst[i]]    <= 1'b1;
                  ram_wr_data[i]             <= in_data[i];
                  ram_wr_addr[i]             <= next_addr[i][hdr_dst[i]];
                end
              end
            end
            PAYLOAD: begin
              ram_wren[i][dst[i]] <= 1'b1;
              ram_wr_data[i]      <= in_data[i];
              ram_wr_addr[i]      <= next_addr[i][dst[i]];
              if (!nonzero[i]) state[i] <= IDLE;
            end
            DROP: begin
              if (!nonzero[i]) state[i] <= IDLE;
            end
            default: state[i] <= IDLE;
          endcase
        end
      end
    end
  end

`ifdef INGRESS_PKT_COUNT_EN
  logic term_wr    [4];
  logic drop_entry [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      term_wr[i]    = (ram_wren[i][0] | ram_wren[i][1] | ram_wren[i][2] | ram_wren[i][3])
                      && (ram_wr_data[i] == '0);
      drop_entry[i] = accept[i] && (state[i] == IDLE) && nonzero[i] && full[i][hdr_dst[i]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        pkt_count[i]  <= '0;
        drop_count[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < 4; i++) begin
        pkt_count[i]  <= '0;
        drop_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (term_wr[i] && pkt_count[i] != 16'hFFFF)     pkt_count[i]  <= pkt_count[i] + 16'd1;
        if (drop_entry[i] && drop_count[i] != 16'hFFFF) drop_count[i] <= drop_count[i] + 16'd1;
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pkt_count[i]  = '0;
      drop_count[i] = '0;
    end
  end
`endif

endmodule

// File: tb/tb_ingress_writer.sv
// Randomized bench for ingress_writer with a queue-occupancy reference model and directed literal checks.
module tb_ingress_writer;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int MAXC = (1 << AW) - 1;
  localparam int M_IDLE = 0, M_PKT = 1, M_DROP = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    reset_rams;
  logic [DW-1:0] in_data          [4];
  logic          in_valid         [4];
  logic          in_ready         [4];
  logic [DW-1:0] ram_wr_data      [4];
  logic [AW-1:0] ram_wr_addr      [4];
  logic          ram_wren         [4][4];
  logic [AW-1:0] input_ram_wr_add [4][4];
  logic [15:0]   pkt_count        [4];
  logic [15:0]   drop_count       [4];

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  ingress_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .reset_rams(reset_rams),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wren(ram_wren),
    .input_ram_wr_add(input_ram_wr_add), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: committed words per queue, one in-flight write per port, packet mode per port.
  int            qlen  [4][4];
  bit            pv    [4];
  int            pd    [4];
  logic [DW-1:0] pdat  [4];
  int            paddr [4];
  int            mode  [4];
  int            mdst  [4];
  int            pk    [4];
  int            dr    [4];
  bit            m_acc [4];

  function automatic int occ(input int p, input int d);
    return qlen[p][d] + ((pv[p] && pd[p] == d) ? 1 : 0);
  endfunction

  function automatic bit mready(input int p);
    if (reset_rams != 2'b00) return 1'b0;
    return !(mode[p] == M_PKT && occ(p, mdst[p]) == MAXC);
  endfunction

  task automatic mclear();
    for (int p = 0; p < 4; p++) begin
      for (int d = 0; d < 4; d++) qlen[p][d] = 0;
      pv[p] = 1'b0; pd[p] = 0; pdat[p] = '0; paddr[p] = 0;
      mode[p] = M_IDLE; mdst[p] = 0; pk[p] = 0; dr[p] = 0; m_acc[p] = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset || reset_rams != 2'b00) begin
      mclear();
    end else begin
      for (int p = 0; p < 4; p++) begin
        bit acc; bit nv; int nd; int naddr; logic [DW-1:0] w;
        acc = in_valid[p] && mready(p);
        w = in_data[p]; nv = 1'b0; nd = 0; naddr = 0;
        if (acc) begin
          if (mode[p] == M_IDLE) begin
            if (w != 0) begin
              if (occ(p, int'(w[1:0])) == MAXC) begin
                mode[p] = M_DROP;
                if (dr[p] < 65535) dr[p]++;
              end else begin
                mode[p] = M_PKT; mdst[p] = int'(w[1:0]); nv = 1'b1; nd = mdst[p];
              end
            end
          end else if (mode[p] == M_PKT) begin
            nv = 1'b1; nd = mdst[p];
            if (w == 0) mode[p] = M_IDLE;
          end else if (w == 0) begin
            mode[p] = M_IDLE;
          end
          if (nv) naddr = occ(p, nd);
        end
        if (pv[p]) begin
          qlen[p][pd[p]]++;
          if (pdat[p] == 0 && pk[p] < 65535) pk[p]++;
        end
        pv[p] = nv; pd[p] = nd; pdat[p] = w; paddr[p] = naddr; m_acc[p] = acc;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int p = 0; p < 4; p++) begin
        int epk; int edr;
        chk($sformatf("in_ready[%0d]", p), in_ready[p], mready(p));
        for (int d = 0; d < 4; d++) begin
          chk($sformatf("ram_wren[%0d][%0d]", p, d), ram_wren[p][d], (pv[p] && pd[p] == d));
          chk($sformatf("wr_add[%0d][%0d]", p, d), input_ram_wr_add[p][d], qlen[p][d]);
        end
        if (pv[p]) begin
          chk($sformatf("ram_wr_data[%0d]", p), ram_wr_data[p], pdat[p]);
          chk($sformatf("ram_wr_addr[%0d]", p), ram_wr_addr[p], paddr[p]);
        end
`ifdef INGRESS_PKT_COUNT_EN
        epk = pk[p]; edr = dr[p];
`else
        epk = 0; edr = 0;
`endif
        chk($sformatf("pkt_count[%0d]", p), pkt_count[p], epk);
        chk($sformatf("drop_count[%0d]", p), drop_count[p], edr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [DW-1:0] words [$], input int budget);
    int k = 0;
    int n = 0;
    while (k < words.size() && n < budget) begin
      in_valid[p] = 1'b1;
      in_data[p]  = words[k];
      cyc();
      if (m_acc[p]) k++;
      n++;
    end
    in_valid[p] = 1'b0;
    chk($sformatf("send_done[%0d]", p), k, words.size());
  endtask

  task automatic rand_port(input int p, input int ncyc);
    logic [DW-1:0] q [$];
    logic [DW-1:0] w;
    for (int c = 0; c < ncyc; c++) begin
      if (q.size() == 0) begin
        if ($urandom_range(0, 7) == 0) q.push_back(32'h0);
        w = $urandom;
        w[1:0] = 2'($urandom_range(0, 3));
        if (w == 0) w = 32'h100;
        q.push_back(w);
        repeat ($urandom_range(0, 5)) begin
          w = $urandom;
          if (w == 0) w = 32'h1;
          q.push_back(w);
        end
        q.push_back(32'h0);
      end
      in_valid[p] = ($urandom_range(0, 9) < 7);
      in_data[p]  = in_valid[p] ? q[0] : DW'($urandom);
      cyc();
      if (m_acc[p]) void'(q.pop_front());
    end
    in_valid[p] = 1'b0;
  endtask

  task automatic rr_pulser(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      reset_rams = ($urandom_range(0, 199) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cyc();
    end
    reset_rams = 2'b00;
  endtask

  task automatic pulse_rr(input logic [1:0] v);
    reset_rams = v;
    cyc();
    reset_rams = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] words [$];
    logic [DW-1:0] seq3 [3];
    logic          anyw;
    int            exp_drop, exp_pkt;

    reset = 1'b1;
    reset_rams = 2'b00;
    for (int p = 0; p < 4; p++) begin
      in_valid[p] = 1'b0;
      in_data[p]  = '0;
    end
    #2;
    cmp_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_ready[%0d]", p), in_ready[p], 1);
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("rst_wren[%0d][%0d]", p, d), ram_wren[p][d], 0);
        chk($sformatf("rst_add[%0d][%0d]", p, d), input_ram_wr_add[p][d], 0);
      end
    end
    cyc();
    reset = 1'b0;
    cyc();

    // Single packet to queue [0][2], words back-to-back.
    seq3[0] = 32'h2; seq3[1] = 32'hAAAA; seq3[2] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = seq3[k];
      cyc();
      chk("r22_wren", ram_wren[0][2], 1);
      chk("r22_addr", ram_wr_addr[0], k);
      chk("r22_data", ram_wr_data[0], seq3[k]);
    end
    in_valid[0] = 1'b0;
    cyc();
    chk("r22_wren_off", ram_wren[0][2], 0);
    chk("r22_count", input_ram_wr_add[0][2], 3);
`ifdef INGRESS_PKT_COUNT_EN
    exp_pkt = 1;
`else
    exp_pkt = 0;
`endif
    chk("r22_pkt_count", pkt_count[0], exp_pkt);

    pulse_rr(2'b01);
    chk("rr_clear_count", input_ram_wr_add[0][2], 0);

    // All four ports in parallel to queue [i][1].
    seq3[0] = 32'h1; seq3[1] = 32'h5; seq3[2] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 4; p++) begin
        in_valid[p] = 1'b1;
        in_data[p]  = seq3[k];
      end
      cyc();
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("r23_wren[%0d]", p), ram_wren[p][1], 1);
        chk($sformatf("r23_addr[%0d]", p), ram_wr_addr[p], k);
      end
    end
    for (int p = 0; p < 4; p++) in_valid[p] = 1'b0;
    cyc();
    for (int p = 0; p < 4; p++) chk($sformatf("r23_count[%0d]", p), input_ram_wr_add[p][1], 3);

    // Stray zero word in IDLE on port 3.
    chk("r27_ready", in_ready[3], 1);
    in_valid[3] = 1'b1;
    in_data[3]  = 32'h0;
    cyc();
    in_valid[3] = 1'b0;
    anyw = ram_wren[3][0] | ram_wren[3][1] | ram_wren[3][2] | ram_wren[3][3];
    chk("r27_no_write", anyw, 0);
    cyc();
    chk("r27_count1", input_ram_wr_add[3][1], 3);
    chk("r27_count0", input_ram_wr_add[3][0], 0);

    // Bring queue [1][3] to 4094 words, then the header fills it.
    words.delete();
    words.push_back(32'h3);
    for (int k = 0; k < 4092; k++) words.push_back(32'h1000 + k);
    words.push_back(32'h0);
    send(1, words, 6000);
    cyc();
    chk("r24_pre", input_ram_wr_add[1][3], 4094);
    in_valid[1] = 1'b1;
    in_data[1]  = 32'h3;
    cyc();
    chk("r24_hdr_wren", ram_wren[1][3], 1);
    chk("r24_hdr_addr", ram_wr_addr[1], 4094);
    chk("r24_ready_low", in_ready[1], 0);
    in_data[1] = 32'h55;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("r24_full_count", input_ram_wr_add[1][3], 4095);
      chk("r24_stay_low", in_ready[1], 0);
    end
    reset_rams = 2'b10;
    cyc();
    reset_rams  = 2'b00;
    in_valid[1] = 1'b0;
    #1;
    chk("r24_ready_back", in_ready[1], 1);
    chk("r24_count_clr", input_ram_wr_add[1][3], 0);

    // Fill queue [2][0] exactly, then a packet to it must be dropped.
    words.delete();
    words.push_back(32'h4);
    for (int k = 0; k < 4093; k++) words.push_back(32'h2000 + k);
    words.push_back(32'h0);
    send(2, words, 6000);
    cyc();
    chk("r25_full", input_ram_wr_add[2][0], 4095);
    seq3[0] = 32'h4; seq3[1] = 32'h7; seq3[2] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      chk("r25_ready", in_ready[2], 1);
      in_valid[2] = 1'b1;
      in_data[2]  = seq3[k];
      cyc();
      anyw = ram_wren[2][0] | ram_wren[2][1] | ram_wren[2][2] | ram_wren[2][3];
      chk("r25_no_write", anyw, 0);
    end
    in_valid[2] = 1'b0;
    cyc();
`ifdef INGRESS_PKT_COUNT_EN
    exp_drop = 1;
`else
    exp_drop = 0;
`endif
    chk("r25_drop_count", drop_count[2], exp_drop);
    in_valid[2] = 1'b1;
    in_data[2]  = 32'h1;
    cyc();
    in_valid[2] = 1'b0;
    chk("r25_idle_hdr", ram_wren[2][1], 1);
    chk("r25_idle_addr", ram_wr_addr[2], 0);
    cyc();

    // Asynchronous reset with a packet in progress.
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h2;
    cyc();
    in_data[0]  = 32'h9;
    cyc();
    in_valid[0] = 1'b0;
    reset = 1'b1;
    #1;
    chk("r26_wren", ram_wren[0][2], 0);
    chk("r26_count", input_ram_wr_add[0][2], 0);
    chk("r26_data", ram_wr_data[0], 0);
    chk("r26_addr", ram_wr_addr[0], 0);
    cyc();
    reset = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h1;
    cyc();
    in_valid[0] = 1'b0;
    chk("r26_new_wren", ram_wren[0][1], 1);
    chk("r26_new_addr", ram_wr_addr[0], 0);
    cyc();
    chk("r26_new_count", input_ram_wr_add[0][1], 1);

    fork
      rand_port(0, 3000);
      rand_port(1, 3000);
      rand_port(2, 3000);
      rand_port(3, 3000);
      rr_pulser(3000);
    join
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ingress_writer.md
INGRESS_WRITER -- requirements
Module: ingress_writer

Interface
REQ-001 Parameters SHALL be: ADDR_W, 12, input-RAM address width; DATA_W, 32, word width.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  the only clock.
- reset  in  1  asynchronous, active-high.
- reset_rams  in  2  synchronous queue clear; any nonzero value clears.
- in_data[4]  in  DATA_W  word from input port i.
- in_valid[4]  in  1  in_data[i] valid.
- in_ready[4]  out  1  port i accepts this cycle.
- ram_wr_data[4]  out  DATA_W  word for input RAM row i.
- ram_wr_addr[4]  out  ADDR_W  write address for row i.
- ram_wren[4][4]  out  1  write strobe, RAM [i][dst].
- input_ram_wr_add[4][4]  out  ADDR_W  word count (next free address) of queue [i][dst].

Function
REQ-003 Packet format SHALL be: nonzero header word with dst = bits [1:0], nonzero payload words, then one all-zero terminator word; all words, header and terminator included, are written to queue [i][dst].
REQ-004 A word on port i SHALL be accepted at an edge where in_valid[i] and in_ready[i] are both high.
REQ-005 Each port SHALL run its own FSM with states IDLE, PAYLOAD and DROP.
REQ-006 IDLE transitions:
- nonzero word accepted, queue [i][dst] not full -> write it, latch dst, enter PAYLOAD.
- nonzero word accepted, queue full -> enter DROP; nothing written.
- zero word accepted -> discard, stay in IDLE.
REQ-007 PAYLOAD transitions: accepted word written to the latched dst; an accepted zero word is written and the FSM returns to IDLE.
REQ-008 DROP SHALL accept and discard words until a zero word is accepted, then return to IDLE.
REQ-009 Write latency SHALL be one cycle. A word accepted at edge N gives, during cycle N+1:
- ram_wren[i][dst]=1, other strobes of row i 0.
- ram_wr_data[i] = the word.
- ram_wr_addr[i] = the pre-increment input_ram_wr_add[i][dst].
REQ-010 input_ram_wr_add[i][dst] SHALL increment by 1 at edge N+1, so the count never exceeds the words committed to RAM.
REQ-011 Queue full SHALL mean input_ram_wr_add plus any write pending in the current cycle equals 2^ADDR_W-1; the count SHALL never wrap.
REQ-012 in_ready[i] SHALL be 1 in IDLE and DROP, and 0 in PAYLOAD while the latched queue is full.
REQ-013 in_ready[i] SHALL be 0 in every state while reset_rams is nonzero.
REQ-014 in_ready SHALL depend only on registered state and reset_rams, never on in_data or in_valid.
REQ-015 The four ports SHALL operate independently with no shared arbitration, since each port owns RAM row i.
REQ-016 ram_wren SHALL be 0 in every cycle without an accepted word from the previous edge.

Reset
REQ-017 Asynchronous reset SHALL clear, immediately:
- all FSMs to IDLE.
- input_ram_wr_add, ram_wren, ram_wr_data and ram_wr_addr to 0.
- pkt_count and drop_count to 0.
REQ-018 A nonzero reset_rams at an edge SHALL have the same effect as reset at that edge. It overrides a simultaneous accept or pending write: that write is suppressed and the count is not incremented.
REQ-019 Reset or reset_rams mid-packet SHALL abandon the packet; the next accepted word is treated as a header.

Configuration
REQ-020 With INGRESS_PKT_COUNT_EN defined:
- pkt_count[4] (out, 16 bit) SHALL increment when a terminator is written for port i.
- drop_count[4] (out, 16 bit) SHALL increment on each entry to DROP.
- both counters SHALL saturate at 16'hFFFF.
REQ-021 Without INGRESS_PKT_COUNT_EN, both ports SHALL exist, be driven constant 0, and contain no counter logic.

Verification
REQ-022 Port 0 sends 0x00000002, 0xAAAA, 0 back-to-back:
- ram_wren[0][2] is high for 3 consecutive cycles with addresses 0, 1, 2.
- input_ram_wr_add[0][2] ends at 3.
REQ-023 All four ports send 0x1, 0x5, 0 simultaneously: all rows write [i][1] in parallel, and each input_ram_wr_add[i][1] = 3.
REQ-024 Preload input_ram_wr_add[1][3]=4094:
- header 0x3 is written and the count becomes 4095.
- in_ready[1] drops and stays low.
- after reset_rams pulses, in_ready[1] returns high and the count is 0.
REQ-025 With queue [2][0] full, port 2 sends 0x4, 0x7, 0:
- no ram_wren[2][*] is asserted.
- the FSM returns to IDLE.
- drop_count[2]=1 with macro, 0 without.
REQ-026 Assert reset after a header and one payload word: outputs clear immediately; the next word 0x1 starts a new packet to queue 1 at address 0.
REQ-027 Port 3 presents a zero word in IDLE: it is accepted and no write or count change occurs.
